mult_share_arbiter: RTL and testbench
=====================================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter ID_W, default 2, requester-index width, equal to clog2(NUM_REQ).
REQ-004 SHALL have ports clk in 1 (clock) and rst_n in 1 (reset), with reset rst_n asynchronous and active-low, and clock clk.
REQ-005 SHALL have port req_valid in NUM_REQ: per-requester operation valid.
REQ-006 SHALL have port req_ready out NUM_REQ: per-requester accept, at most one bit set.
REQ-007 SHALL have port req_a in NUM_REQ*DATA_WIDTH: packed operand A, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_b in NUM_REQ*DATA_WIDTH: packed operand B, same packing as req_a.
REQ-009 SHALL have port rsp_valid out 1: result valid.
REQ-010 SHALL have port rsp_ready in 1: consumer accepts result.
REQ-011 SHALL have port rsp_id out ID_W: index of the requester owning the result.
REQ-012 SHALL have port rsp_product out 2*DATA_WIDTH: unsigned product A*B.
REQ-013 SHALL have port busy out 1: any pipeline stage occupied.
REQ-014 SHALL have port op_count out 16: number of completed results, wrapping.

Function
REQ-015 SHALL use a 2-stage pipeline: S1 registers granted operands, id and valid; S2 registers the unsigned product of S1 operands (full 2*DATA_WIDTH, no truncation), id and valid.
REQ-016 SHALL perform a request handshake on any cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 SHALL make the response handshake the cycle where rsp_valid and rsp_ready are both high.
REQ-018 SHALL advance S2 (s2_adv) when S2 is empty or the response handshake occurs; SHALL advance S1 (s1_adv) when S1 is empty or s2_adv is high.
REQ-019 SHALL drive req_ready combinationally: one-hot to the arbitration winner among high req_valid bits when s1_adv is high, else all zero.
REQ-020 SHALL NOT make req_ready depend on any req_valid of a losing requester's data; operands SHALL be sampled only on handshake.
REQ-021 SHALL give a latency of exactly 2 cycles with no stall: handshake on edge N gives rsp_valid high after edge N+2, with the matching rsp_id and rsp_product.
REQ-022 SHALL sustain throughput of one operation per cycle while rsp_ready stays high.
REQ-023 SHALL, while rsp_valid is high and rsp_ready is low, hold rsp_valid, rsp_id and rsp_product stable; S1 SHALL hold if full, and no new grant SHALL occur if S1 is full.
REQ-024 SHALL assert no req_ready when no req_valid is high, with pipeline bubbles propagating normally.
REQ-025 SHALL increment op_count by 1 per response handshake, wrapping 16'hFFFF to 0.
REQ-026 SHALL drive busy as S1 valid OR S2 valid.

Reset
REQ-027 SHALL on rst_n low asynchronously clear S1/S2 valid, ids and data, op_count to 0, and the round-robin pointer to NUM_REQ-1, so requester 0 has first priority.
REQ-028 SHALL drive req_ready 0, rsp_valid 0, rsp_id 0, rsp_product 0 and busy 0 during reset; in-flight operations SHALL be discarded and no result SHALL be produced for them.
REQ-029 SHALL make the first grant possible on the first clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro MULT_ARB_ROUND_ROBIN_EN defined, arbitrate round-robin: search starts at last_grant+1 modulo NUM_REQ, and the pointer updates only on request handshake.
REQ-031 SHALL, without MULT_ARB_ROUND_ROBIN_EN, arbitrate fixed priority (lowest index wins), with no pointer register present.

Verification
REQ-032 SHALL cover single op: req 0 with A=8'd13, B=8'd11, rsp_ready=1 -> rsp_valid 2 cycles later, rsp_id=0, rsp_product=16'd143, op_count=1.
REQ-033 SHALL cover extremes: A=8'hFF, B=8'hFF -> 16'hFE01; A=0, B=8'hFF -> 16'h0000.
REQ-034 SHALL cover all requesters constantly valid with MULT_ARB_ROUND_ROBIN_EN -> grants 0,1,2,3,0,... one per cycle; without the macro -> requester 0 every cycle.
REQ-035 SHALL cover backpressure: 3 back-to-back ops, rsp_ready low for 4 cycles -> rsp data held stable, exactly 2 ops in flight, no req_ready high, all 3 results delivered in order after release.
REQ-036 SHALL cover reset mid-operation: rst_n low while S1 and S2 are full -> rsp_valid=0, busy=0, op_count=0, with no stale result after release.
REQ-037 SHALL cover op_count wrap: 65536 completions -> op_count returns to 0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Shared 2-stage unsigned multiplier serving NUM_REQ requesters through an arbiter.
// Define MULT_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority.
module mult_share_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [2*DATA_WIDTH-1:0]       rsp_product,
    output logic                          busy,
    output logic [15:0]                   op_count
);

    logic                    s1_valid;
    logic [ID_W-1:0]         s1_id;
    logic [DATA_WIDTH-1:0]   s1_a;
    logic [DATA_WIDTH-1:0]   s1_b;
    logic                    s2_valid;
    logic [ID_W-1:0]         s2_id;
    logic [2*DATA_WIDTH-1:0] s2_prod;

    logic                    s1_adv;
    logic                    s2_adv;
    logic                    req_hs;
    logic                    grant_any;
    logic [ID_W-1:0]         grant_id;
    logic [NUM_REQ-1:0]      grant_vec;
    logic [ID_W-1:0]         cand;
    logic [DATA_WIDTH-1:0]   grant_a;
    logic [DATA_WIDTH-1:0]   grant_b;

`ifdef MULT_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]         rr_ptr;
`endif

    assign s2_adv = !s2_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // Search order starts just after the last winner in round-robin mode, at index 0 otherwise.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        grant_vec = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef MULT_ARB_ROUND_ROBIN_EN
            cand = ID_W'((32'(rr_ptr) + 32'd1 + k) % NUM_REQ);
`else
            cand = ID_W'(k);
`endif
            if (!grant_any && req_valid[cand]) begin
                grant_any       = 1'b1;
                grant_id        = cand;
                grant_vec[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == grant_id) begin
                grant_a = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                grant_b = req_b[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // rst_n gates the grant so nothing is accepted while reset is held.
    assign req_ready = (rst_n && s1_adv && grant_any) ? grant_vec : '0;
    assign req_hs    = |req_ready;

    assign rsp_valid   = s2_valid;
    assign rsp_id      = s2_id;
    assign rsp_product = s2_prod;
    assign busy        = s1_valid || s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_prod  <= '0;
            op_count <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= req_hs;
                if (req_hs) begin
                    s1_id <= grant_id;
                    s1_a  <= grant_a;
                    s1_b  <= grant_b;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_id   <= s1_id;
                    s2_prod <= (2*DATA_WIDTH)'(s1_a) * (2*DATA_WIDTH)'(s1_b);
                end
            end
            if (s2_valid && rsp_ready) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

`ifdef MULT_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (req_hs) begin
            rr_ptr <= grant_id;
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Honours MULT_ARB_ROUND_ROBIN_EN to select the expected arbitration policy.
module tb_mult_share_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [2*DW-1:0]  rsp_product;
    logic             busy;
    logic [15:0]      op_count;

    mult_share_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .ID_W      (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_product(rsp_product),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [IW-1:0]   id;
        logic [2*DW-1:0] prod;
        int              hs;
    } op_t;

    // Model: at most two operations in flight, delivered in order; each result appears
    // two cycles after its request handshake and never sooner than one cycle after the previous delivery.
    op_t         q[$];
    logic [15:0] cnt = '0;
    int          last_deliver = -100;
    int          last_grant = NR - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v);
`ifdef MULT_ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= NR; i++) begin
            int c;
            c = (last_grant + i) % NR;
            if (v[c]) return c;
        end
`else
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    always @(negedge clk) begin : cmp
        logic          exp_rv;
        logic          exp_acc;
        logic [NR-1:0] exp_rdy;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        int            w;
        op_t           e;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_id", 32'(rsp_id), 32'd0);
            check("rst_rsp_product", 32'(rsp_product), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_op_count", 32'(op_count), 32'd0);
            q.delete();
            cnt = '0;
            last_deliver = -100;
            last_grant = NR - 1;
        end else begin
            exp_rv = 1'b0;
            if (q.size() > 0)
                exp_rv = (cyc >= q[0].hs + 2) && (cyc >= last_deliver + 1);
            exp_acc = (q.size() < 2) || (exp_rv && rsp_ready);
            w = pick(req_valid);
            exp_rdy = '0;
            if (exp_acc && w >= 0) exp_rdy[w] = 1'b1;

            check("m_req_ready", 32'(req_ready), 32'(exp_rdy));
            check("m_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("m_busy", 32'(busy), 32'(q.size() != 0));
            check("m_op_count", 32'(op_count), 32'(cnt));
            if (exp_rv) begin
                check("m_rsp_id", 32'(rsp_id), 32'(q[0].id));
                check("m_rsp_product", 32'(rsp_product), 32'(q[0].prod));
            end

            if (exp_rv && rsp_ready) begin
                void'(q.pop_front());
                last_deliver = cyc;
                cnt = cnt + 16'd1;
            end
            if (exp_rdy != '0) begin
                opa    = req_a[w*DW +: DW];
                opb    = req_b[w*DW +: DW];
                e.id   = IW'(w);
                e.prod = 16'(int'(opa) * int'(opb));
                e.hs   = cyc;
                q.push_back(e);
                last_grant = w;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[idx*DW +: DW] = a;
        req_b[idx*DW +: DW] = b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] e_rdy;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // reset values
        #2 rst_n = 1'b0;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_op_count", 32'(op_count), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // single op, requested in the same cycle reset is released
        rst_n = 1'b1;
        set_op(0, 8'd13, 8'd11);
        req_valid = 4'b0001;
        #1 check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("t1_busy_s1", 32'(busy), 32'd1);
        check("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        check("t1_rsp_product", 32'(rsp_product), 32'd143);
        tick();
        check("t1_op_count", 32'(op_count), 32'd1);
        check("t1_idle", 32'(rsp_valid), 32'd0);
        tick();

        // extremes on two requesters back to back
        set_op(1, 8'hFF, 8'hFF);
        req_valid = 4'b0010;
        #1 check("t2_ready_1", 32'(req_ready), 32'h2);
        tick();
        set_op(2, 8'h00, 8'hFF);
        req_valid = 4'b0100;
        #1 check("t2_ready_2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        check("t2_id_ff", 32'(rsp_id), 32'd1);
        check("t2_prod_ff", 32'(rsp_product), 32'hFE01);
        tick();
        check("t2_id_zero", 32'(rsp_id), 32'd2);
        check("t2_prod_zero", 32'(rsp_product), 32'h0000);
        check("t2_valid_zero", 32'(rsp_valid), 32'd1);
        tick();
        tick();

        // backpressure: three ops, consumer stalled for four cycles
        rsp_ready = 1'b0;
        set_op(0, 8'd3, 8'd5);
        req_valid = 4'b0001;
        tick();
        set_op(1, 8'd7, 8'd9);
        req_valid = 4'b0010;
        tick();
        set_op(2, 8'd200, 8'd2);
        req_valid = 4'b0100;
        #1;
        check("t3_full_ready_a", 32'(req_ready), 32'd0);
        check("t3_hold_valid_a", 32'(rsp_valid), 32'd1);
        check("t3_hold_prod_a", 32'(rsp_product), 32'd15);
        check("t3_busy", 32'(busy), 32'd1);
        tick();
        check("t3_full_ready_b", 32'(req_ready), 32'd0);
        check("t3_hold_prod_b", 32'(rsp_product), 32'd15);
        check("t3_hold_id_b", 32'(rsp_id), 32'd0);
        tick();
        rsp_ready = 1'b1;
        #1;
        check("t3_release_ready", 32'(req_ready), 32'h4);
        check("t3_prod_0", 32'(rsp_product), 32'd15);
        tick();
        req_valid = '0;
        check("t3_id_1", 32'(rsp_id), 32'd1);
        check("t3_prod_1", 32'(rsp_product), 32'd63);
        tick();
        check("t3_id_2", 32'(rsp_id), 32'd2);
        check("t3_prod_2", 32'(rsp_product), 32'd400);
        tick();
        check("t3_drained", 32'(rsp_valid), 32'd0);
        tick();

        // reset with both stages full
        rsp_ready = 1'b0;
        set_op(3, 8'd10, 8'd10);
        req_valid = 4'b1000;
        tick();
        set_op(0, 8'd4, 8'd4);
        req_valid = 4'b0001;
        tick();
        #1;
        check("t4_full_busy", 32'(busy), 32'd1);
        check("t4_full_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_valid", 32'(rsp_valid), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_count", 32'(op_count), 32'd0);
        check("t4_rst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_no_stale", 32'(rsp_valid), 32'd0);
        end

        // all requesters valid every cycle
        for (int k = 0; k < NR; k++) set_op(k, 8'(k + 1), 8'(k + 20));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
`ifdef MULT_ARB_ROUND_ROBIN_EN
            e_rdy = 4'b0001 << (k % 4);
`else
            e_rdy = 4'b0001;
`endif
            #1 check("t5_grant", 32'(req_ready), 32'(e_rdy));
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // op_count wrap after 65536 completions
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 65536; i++) begin
            for (int k = 0; k < NR; k++) set_op(k, 8'(i + k), 8'(i * 3 + k));
            tick();
        end
        req_valid = '0;
        tick();
        check("t6_count_ffff", 32'(op_count), 32'hFFFF);
        tick();
        check("t6_count_wrap", 32'(op_count), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
